// File: rtl/ntt_poly_serializer.sv
`default_nettype none
// ============================================================================
// Module : ntt_poly_serializer
// Drains a 256-coefficient polynomial from the NTT parallel output and streams
// it one coefficient per beat. Optional macro: NTT_SER_CANON_EN (mod-q output).
// Revision: 1.0 - initial release
// ============================================================================
module ntt_poly_serializer #(
  parameter int DATA_W     = 16,
  parameter int N_GROUPS   = 8,
  parameter int GROUP_SIZE = 32,
  localparam int IDX_W     = $clog2(N_GROUPS * GROUP_SIZE)
) (
  input  logic                                            i_clk,
  input  logic                                            i_rst,
  input  logic                                            i_valid,
  input  logic [N_GROUPS-1:0][GROUP_SIZE-1:0][DATA_W-1:0] i_data,
  input  logic                                            i_ready,
  output logic                                            o_valid,
  output logic signed [DATA_W-1:0]                        o_data,
  output logic [IDX_W-1:0]                                o_idx,
  output logic                                            o_last,
  output logic                                            o_busy,
  output logic                                            o_drop
);

  localparam int               ELEM_W   = $clog2(GROUP_SIZE);
  localparam logic [IDX_W-1:0] C_LAST   = IDX_W'(N_GROUPS * GROUP_SIZE - 1);
  localparam logic [0:0]       S_IDLE   = 1'b0;
  localparam logic [0:0]       S_STREAM = 1'b1;

  logic [0:0]                                       state_q, state_d;
  logic [IDX_W-1:0]                                 idx_q, idx_d;
  logic [N_GROUPS-1:0][GROUP_SIZE-1:0][DATA_W-1:0]  buf_q, buf_d;
  logic                                             drop_q, drop_d;
  logic                                             beat, final_beat, load;
  logic signed [DATA_W-1:0]                         raw;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      buf_q   <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      drop_q  <= drop_d;
    end
  end

  // A new block is accepted from idle, or on the final beat so streams abut.
  always_comb begin
    beat       = (state_q == S_STREAM) && i_ready;
    final_beat = beat && (idx_q == C_LAST);
    load       = i_valid && ((state_q == S_IDLE) || final_beat);
    state_d    = state_q;
    case (state_q)
      S_IDLE:   if (i_valid) state_d = S_STREAM;
      S_STREAM: if (final_beat && !i_valid) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    idx_d = idx_q;
    if (load) begin
      idx_d = '0;
    end else if (beat) begin
      idx_d = idx_q + IDX_W'(1);
    end
    buf_d  = load ? i_data : buf_q;
    drop_d = i_valid && (state_q == S_STREAM) && !final_beat;
  end

  assign raw = buf_q[idx_q[IDX_W-1:ELEM_W]][idx_q[ELEM_W-1:0]];

`ifdef NTT_SER_CANON_EN
  localparam logic signed [DATA_W:0] C_Q  = (DATA_W+1)'(3329);
  localparam logic signed [DATA_W:0] C_2Q = (DATA_W+1)'(6658);
  logic signed [DATA_W:0] ext, lifted, reduced;
`endif

  always_comb begin
    o_valid = (state_q == S_STREAM);
    o_busy  = (state_q == S_STREAM);
    o_last  = (state_q == S_STREAM) && (idx_q == C_LAST);
    o_idx   = idx_q;
    o_drop  = drop_q;
`ifdef NTT_SER_CANON_EN
    ext     = {raw[DATA_W-1], raw};
    lifted  = ext[DATA_W] ? (ext + C_2Q) : ext;
    reduced = (lifted >= C_Q) ? (lifted - C_Q) : lifted;
    o_data  = reduced[DATA_W-1:0];
`else
    o_data  = raw;
`endif
  end

endmodule
`default_nettype wire
